// File: rtl/wb_timer_multi.sv
// wb_timer_multi: NUM_CH Wishbone-mapped up-counters with free-run,
// auto-reload and one-shot modes, event/gate sources, sticky OVF + irq.
// Ports: clk, reset_n (async, active-low); Wishbone stb_i/we_i/adr_wr_i/
// adr_rd_i/dat_i -> dat_o/ack_o; unit_pulse, event_pulse, INTx count
// inputs; timer_trigger (1-cycle overflow pulse) and irq_o (OVF & IE).
module wb_timer_multi #(
  parameter int NUM_CH        = 2,
  parameter int CNT_WIDTH     = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 8,
  parameter int REG_ADDR_BASE = 'h80
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_wr_i,
  input  logic [ADDR_WIDTH-1:0] adr_rd_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  ack_o,
  input  logic                  unit_pulse,
  input  logic [NUM_CH-1:0]     event_pulse,
  input  logic [NUM_CH-1:0]     INTx,
  output logic [NUM_CH-1:0]     timer_trigger,
  output logic [NUM_CH-1:0]     irq_o
);

  localparam int NB  = CNT_WIDTH / DATA_WIDTH;
  localparam int CHW = ADDR_WIDTH - 4;
  localparam int SW  = (NB > 1) ? CNT_WIDTH - DATA_WIDTH : 1;
  localparam int LIM = REG_ADDR_BASE + 16 * NUM_CH;

  localparam logic [ADDR_WIDTH:0] BASE_X =
    (ADDR_WIDTH+1)'(REG_ADDR_BASE);
  localparam logic [ADDR_WIDTH:0] LIM_X =
    (ADDR_WIDTH+1)'(LIM);

  // Per-channel state
  logic [NUM_CH-1:0][5:0]           ctrl_q, ctrl_d;
  logic [NUM_CH-1:0]                ovf_q, ovf_d;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0] rel_q, rel_d;
  logic [NUM_CH-1:0][SW-1:0]        snap_q, snap_d;
  logic [NUM_CH-1:0]                ev_q;
  logic [NUM_CH-1:0]                trig_q;
  logic [NUM_CH-1:0]                irq_q, irq_d;
  logic [NUM_CH-1:0]                tick;
  logic [NUM_CH-1:0]                ovf_ev;

  // Address decode, write and read sides
  logic [ADDR_WIDTH-1:0] w_off, r_off;
  logic                  w_ok, r_ok;
  logic [CHW-1:0]        w_ch, r_ch;
  logic [3:0]            w_reg, r_reg;
  logic                  wr_hit, rd_hit;

  assign w_off = adr_wr_i - BASE_X[ADDR_WIDTH-1:0];
  assign r_off = adr_rd_i - BASE_X[ADDR_WIDTH-1:0];
  assign w_ok  = ({1'b0, adr_wr_i} >= BASE_X) &&
                 ({1'b0, adr_wr_i} <  LIM_X);
  assign r_ok  = ({1'b0, adr_rd_i} >= BASE_X) &&
                 ({1'b0, adr_rd_i} <  LIM_X);
  assign w_ch  = w_off[ADDR_WIDTH-1:4];
  assign r_ch  = r_off[ADDR_WIDTH-1:4];
  assign w_reg = w_off[3:0];
  assign r_reg = r_off[3:0];

  assign wr_hit = stb_i & we_i & w_ok;
  assign rd_hit = stb_i & ~we_i & r_ok;

  assign ack_o         = stb_i;
  assign timer_trigger = trig_q;
  assign irq_o         = irq_q;

  // Next-state for every channel
  always_comb begin
    logic                 w_sel;
    logic                 cnt_wr;
    logic                 full;
    logic                 src;
    logic                 ev_edge;
    logic [1:0]           mode;
    logic [CNT_WIDTH-1:0] cw;
    logic [CNT_WIDTH-1:0] rw;
    w_sel   = 1'b0;
    cnt_wr  = 1'b0;
    full    = 1'b0;
    src     = 1'b0;
    ev_edge = 1'b0;
    mode    = 2'b00;
    cw      = '0;
    rw      = '0;
    tick    = '0;
    ovf_ev  = '0;
    irq_d   = '0;
    ctrl_d  = ctrl_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    snap_d  = snap_q;
    for (int c = 0; c < NUM_CH; c++) begin
      w_sel  = wr_hit && (w_ch == CHW'(c));
      mode   = ctrl_q[c][2:1];
      cw     = cnt_q[c];
      rw     = rel_q[c];
      cnt_wr = 1'b0;
      for (int b = 0; b < NB; b++) begin
        if (w_sel && (w_reg == 4'(2 + b))) begin
          cw[b*DATA_WIDTH +: DATA_WIDTH] = dat_i;
          cnt_wr = 1'b1;
        end
        if (w_sel && (w_reg == 4'(6 + b))) begin
          rw[b*DATA_WIDTH +: DATA_WIDTH] = dat_i;
        end
      end

      ev_edge   = event_pulse[c] & ~ev_q[c];
      src       = ctrl_q[c][3] ? ev_edge : unit_pulse;
      tick[c]   = ctrl_q[c][0] & src &
                  (~ctrl_q[c][4] | INTx[c]);
      full      = &cnt_q[c];
      // A counter write swallows this cycle's tick, overflow included.
      ovf_ev[c] = tick[c] & full & ~cnt_wr;

      if (cnt_wr) begin
        cnt_d[c] = cw;
      end else if (tick[c]) begin
        if (full) begin
          cnt_d[c] = (mode == 2'b01 || mode == 2'b10) ?
                     rel_q[c] : '0;
        end else begin
          cnt_d[c] = cnt_q[c] + 1'b1;
        end
      end

      rel_d[c] = rw;

      if (ovf_ev[c] && mode == 2'b10) begin
        ctrl_d[c][0] = 1'b0;
      end
      if (w_sel && w_reg == 4'd0) begin
        ctrl_d[c] = dat_i[5:0];
      end

      if (w_sel && w_reg == 4'd1 && dat_i[0]) begin
        ovf_d[c] = 1'b0;
      end
      if (ovf_ev[c]) begin
        ovf_d[c] = 1'b1;
      end

      // Reading CNT byte 0 freezes the upper bytes for the next reads.
      if (rd_hit && r_ch == CHW'(c) && r_reg == 4'd2) begin
        snap_d[c] = SW'(cnt_q[c] >> DATA_WIDTH);
      end

      irq_d[c] = ovf_q[c] & ctrl_q[c][5];
    end
  end

  // Read mux
  always_comb begin
    dat_o = '0;
    if (r_ok) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (r_ch == CHW'(c)) begin
          if (r_reg == 4'd0) begin
            dat_o = DATA_WIDTH'(ctrl_q[c]);
          end
          if (r_reg == 4'd1) begin
            dat_o = DATA_WIDTH'(ovf_q[c]);
          end
          if (r_reg == 4'd2) begin
            dat_o = cnt_q[c][DATA_WIDTH-1:0];
          end
          for (int b = 1; b < NB; b++) begin
            if (r_reg == 4'(2 + b)) begin
              dat_o = snap_q[c][(b-1)*DATA_WIDTH +: DATA_WIDTH];
            end
          end
          for (int b = 0; b < NB; b++) begin
            if (r_reg == 4'(6 + b)) begin
              dat_o = rel_q[c][b*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q <= '0;
      ovf_q  <= '0;
      cnt_q  <= '0;
      rel_q  <= '0;
      snap_q <= '0;
      ev_q   <= '0;
      trig_q <= '0;
      irq_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
      rel_q  <= rel_d;
      snap_q <= snap_d;
      ev_q   <= event_pulse;
      trig_q <= ovf_ev;
      irq_q  <= irq_d;
    end
  end

endmodule
